// File: rtl/bwr_drain_engine_pkg.sv
// ============================================================================
// Module : bwr_drain_engine_pkg
// Brief  : Shared error codes, FSM encoding and error-word helper for the
//          buffered block-write drain engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bwr_drain_engine_pkg;

    localparam logic [7:0] ERR_ACK_TO = 8'h01;
    localparam logic [7:0] ERR_OVF    = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    function automatic logic [31:0] make_err(input logic [7:0] code, input logic [23:0] detail);
        return {code, detail};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bwr_sync_fifo.sv
// ============================================================================
// Module : bwr_sync_fifo
// Brief  : Single-clock FIFO with registered 1-cycle read and occupancy count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bwr_sync_fifo #(
    parameter int WIDTH      = 28,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int DEPTH = 2**DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [WIDTH-1:0]      r_rd_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_full  = (r_level == (DEPTH_LOG2+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = i_wr_en && !w_full;
    assign w_pop   = i_rd_en && !w_empty;

    // Storage is left unreset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_level   = r_level;

endmodule

`default_nettype wire

// File: rtl/bwr_drain_engine.sv
// ============================================================================
// Module : bwr_drain_engine
// Brief  : Buffers {adr,data} writes and drains them onto the logic bus with a
//          4-phase req/ack handshake; reports ack timeouts and FIFO overflow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bwr_drain_engine
    import bwr_drain_engine_pkg::*;
#(
    parameter int ADR_W      = 12,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 11,
    parameter int ACK_TO     = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_wr_req,
    input  logic [ADR_W-1:0]      in_adr,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_full,
    output logic [DEPTH_LOG2:0]   in_level,
    input  logic                  mode_auto,
    input  logic                  flush_req,
    output logic                  drain_busy,
    output logic                  drain_done,
    output logic [ADR_W-1:0]      logic_adr,
    output logic [DATA_W-1:0]     logic_wr_data,
    output logic                  logic_wr_req,
    input  logic                  logic_ack,
    output logic                  err_req,
    input  logic                  err_ack,
    output logic [31:0]           err_data,
    output logic                  err_overrun
);

    localparam int CNT_W = (ACK_TO > 1) ? $clog2(ACK_TO + 1) : 1;

    state_t                    r_state;
    state_t                    w_next;
    logic [ADR_W+DATA_W-1:0]   w_fifo_rd_data;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_load;
    logic                      w_clr_req;
    logic                      w_timeout;
    logic                      w_to_hit;
    logic                      w_drain_en;
    logic                      w_flush_done;
    logic                      w_ovf;
    logic                      w_err_valid;
    logic                      w_err_free;
    logic [31:0]               w_err_word;
    logic                      r_req;
    logic [ADR_W-1:0]          r_adr;
    logic [DATA_W-1:0]         r_data;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_flush;
    logic                      r_err_req;
    logic [31:0]               r_err_data;
    logic                      r_overrun;

    bwr_sync_fifo #(
        .WIDTH      (ADR_W + DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (in_wr_req),
        .i_wr_data  ({in_adr, in_data}),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_rd_data),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (in_level)
    );

    assign w_drain_en   = (mode_auto || r_flush) && !w_empty;
    assign w_flush_done = r_flush && (r_state == S_IDLE) && w_empty;
    // Counter is preloaded to 1 when req rises, so req stays high ACK_TO cycles.
    assign w_to_hit     = (ACK_TO != 0) && (r_cnt == CNT_W'(ACK_TO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_clr_req = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_drain_en) begin
                    w_pop  = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_load = 1'b1;
                w_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (logic_ack) begin
                    w_clr_req = 1'b1;
                    w_next    = S_WAIT_REL;
                end else if (w_to_hit) begin
                    w_clr_req = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (!logic_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_adr  <= '0;
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_load) begin
                {r_adr, r_data} <= w_fifo_rd_data;
                r_req           <= 1'b1;
                r_cnt           <= CNT_W'(1);
            end else if (w_clr_req) begin
                r_req <= 1'b0;
            end else if (r_state == S_WAIT_ACK) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush <= 1'b0;
        end else if (flush_req) begin
            r_flush <= 1'b1;
        end else if (w_flush_done) begin
            r_flush <= 1'b0;
        end
    end

    // A timeout coinciding with an overflow keeps the timeout and flags the loss.
    assign w_ovf       = in_wr_req && w_full;
    assign w_err_valid = w_timeout || w_ovf;
    assign w_err_free  = !r_err_req || err_ack;
    assign w_err_word  = w_timeout ? make_err(ERR_ACK_TO, 24'(r_adr))
                                   : make_err(ERR_OVF, 24'(in_adr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_req  <= 1'b0;
            r_err_data <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_err_valid && w_err_free) begin
                r_err_req  <= 1'b1;
                r_err_data <= w_err_word;
            end else if (err_ack) begin
                r_err_req <= 1'b0;
            end
            r_overrun <= (w_err_valid && !w_err_free) || (w_timeout && w_ovf);
        end
    end

    assign in_full       = w_full;
    assign drain_busy    = (r_state != S_IDLE);
    assign drain_done    = w_flush_done;
    assign logic_adr     = r_adr;
    assign logic_wr_data = r_data;
    assign logic_wr_req  = r_req;
    assign err_req       = r_err_req;
    assign err_data      = r_err_data;
    assign err_overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_bwr_drain_engine.sv
// ============================================================================
// Module : tb_bwr_drain_engine
// Brief  : Self-checking bench for bwr_drain_engine (depth 4, ack timeout 10).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bwr_drain_engine;

    localparam int ADR_W      = 12;
    localparam int DATA_W     = 16;
    localparam int DEPTH_LOG2 = 2;
    localparam int ACK_TO     = 10;
    localparam int DEPTH      = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_wr_req = 1'b0;
    logic [ADR_W-1:0]    in_adr = '0;
    logic [DATA_W-1:0]   in_data = '0;
    logic                in_full;
    logic [DEPTH_LOG2:0] in_level;
    logic                mode_auto = 1'b0;
    logic                flush_req = 1'b0;
    logic                drain_busy;
    logic                drain_done;
    logic [ADR_W-1:0]    logic_adr;
    logic [DATA_W-1:0]   logic_wr_data;
    logic                logic_wr_req;
    logic                logic_ack = 1'b0;
    logic                err_req;
    logic                err_ack = 1'b0;
    logic [31:0]         err_data;
    logic                err_overrun;

    int n_vec = 0;
    int n_bad = 0;

    bwr_drain_engine #(
        .ADR_W      (ADR_W),
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .ACK_TO     (ACK_TO)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_wr_req     (in_wr_req),
        .in_adr        (in_adr),
        .in_data       (in_data),
        .in_full       (in_full),
        .in_level      (in_level),
        .mode_auto     (mode_auto),
        .flush_req     (flush_req),
        .drain_busy    (drain_busy),
        .drain_done    (drain_done),
        .logic_adr     (logic_adr),
        .logic_wr_data (logic_wr_data),
        .logic_wr_req  (logic_wr_req),
        .logic_ack     (logic_ack),
        .err_req       (err_req),
        .err_ack       (err_ack),
        .err_data      (err_data),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
        in_wr_req = 1'b1;
        in_adr    = a;
        in_data   = d;
        step();
        in_wr_req = 1'b0;
    endtask

    // Waits (bounded) for a write request, checks it against the expected entry,
    // holds it for dly cycles, then completes the 4-phase handshake.
    task automatic serve(input int dly, input logic [ADR_W+DATA_W-1:0] exp_e);
        int n;
        n = 0;
        while (!logic_wr_req && n < 40) begin
            step();
            n++;
        end
        chk("serve_req_seen", logic_wr_req, 1);
        chk("serve_entry", {logic_adr, logic_wr_data}, exp_e);
        repeat (dly) begin
            step();
            chk("serve_hold", {logic_wr_req, logic_adr, logic_wr_data}, {1'b1, exp_e});
        end
        logic_ack = 1'b1;
        step();
        chk("serve_req_fall", logic_wr_req, 0);
        chk("serve_stable_after_ack", {logic_adr, logic_wr_data}, exp_e);
        chk("serve_busy_rel", drain_busy, 1);
        logic_ack = 1'b0;
        step();
    endtask

    initial begin
        logic [ADR_W+DATA_W-1:0] ent [5];
        logic [ADR_W+DATA_W-1:0] q [$];
        logic [ADR_W+DATA_W-1:0] cur;
        logic [ADR_W-1:0]        a_to;
        logic [ADR_W-1:0]        b_to;
        int                      n;
        int                      n_ovr;
        int                      outst;
        int                      dly;
        bit                      active;

        // Reset state
        step();
        step();
        chk("rst_outputs", {in_full, in_level, drain_busy, drain_done, logic_wr_req,
                            logic_adr, logic_wr_data, err_req, err_data, err_overrun}, '0);
        rst = 1'b0;
        step();

        // Auto mode: latency, handshake and release with random entries/ack delays
        mode_auto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cur = (i == 0) ? {12'h123, 16'hBEEF} : (ADR_W+DATA_W)'($urandom);
            push(cur[ADR_W+DATA_W-1:DATA_W], cur[DATA_W-1:0]);
            step();
            chk("lat_edge1_low", logic_wr_req, 0);
            step();
            chk("lat_edge2_high", logic_wr_req, 1);
            serve((i == 0) ? 3 : int'($urandom_range(0, 5)), cur);
            chk("auto_idle_after_rel", drain_busy, 0);
        end

        // Manual mode: fill, overflow error, hold-off, then flush drain
        mode_auto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ent[i] = (ADR_W+DATA_W)'($urandom);
            if (i == 4) chk("ovf_no_err_before", err_req, 0);
            push(ent[i][ADR_W+DATA_W-1:DATA_W], ent[i][DATA_W-1:0]);
            if (i == 3) chk("full_after_4th", in_full, 1);
            if (i == 2) chk("not_full_after_3rd", in_full, 0);
        end
        chk("ovf_err_req", err_req, 1);
        chk("ovf_err_data", err_data, {8'h02, 12'h000, ent[4][ADR_W+DATA_W-1:DATA_W]});
        chk("ovf_level", in_level, DEPTH);
        n = 0;
        repeat (50) begin
            step();
            if (logic_wr_req) n++;
        end
        chk("manual_no_req", n, 0);
        chk("manual_level", in_level, DEPTH);
        chk("ovf_err_stable", {err_req, err_data},
            {1'b1, 8'h02, 12'h000, ent[4][ADR_W+DATA_W-1:DATA_W]});
        err_ack = 1'b1;
        step();
        err_ack = 1'b0;
        chk("ovf_err_cleared", err_req, 0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_no_early_done", drain_done, 0);
            serve(int'($urandom_range(0, 4)), ent[i]);
        end
        chk("flush_done_pulse", drain_done, 1);
        chk("flush_level_zero", in_level, 0);
        step();
        chk("flush_done_one_cycle", drain_done, 0);

        // Flush with an empty FIFO
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("empty_flush_done", drain_done, 1);
        step();
        chk("empty_flush_done_clear", drain_done, 0);

        // Two ack timeouts without err_ack
        a_to = ADR_W'($urandom);
        b_to = a_to ^ 12'hA5A;
        push(a_to, DATA_W'($urandom));
        push(b_to, DATA_W'($urandom));
        mode_auto = 1'b1;
        n = 0;
        while (!logic_wr_req && n < 10) begin
            step();
            n++;
        end
        chk("to1_adr", {logic_wr_req, logic_adr}, {1'b1, a_to});
        n = 0;
        while (logic_wr_req && n < 40) begin
            n++;
            step();
        end
        chk("to1_req_len", n, ACK_TO);
        chk("to1_err", {err_req, err_data}, {1'b1, 8'h01, 12'h000, a_to});
        n = 0;
        while (!logic_wr_req && n < 10) begin
            step();
            n++;
        end
        chk("to2_next_issued", {logic_wr_req, logic_adr}, {1'b1, b_to});
        n = 0;
        n_ovr = 0;
        repeat (25) begin
            if (logic_wr_req) n++;
            if (err_overrun) n_ovr++;
            step();
        end
        chk("to2_req_len", n, ACK_TO);
        chk("to2_overrun_once", n_ovr, 1);
        chk("to2_err_held", {err_req, err_data}, {1'b1, 8'h01, 12'h000, a_to});
        err_ack = 1'b1;
        step();
        err_ack = 1'b0;
        chk("to_err_cleared", err_req, 0);

        // Reset in the middle of a handshake
        mode_auto = 1'b0;
        for (int i = 0; i < 4; i++) push(ADR_W'($urandom), DATA_W'($urandom));
        mode_auto = 1'b1;
        n = 0;
        while (!logic_wr_req && n < 10) begin
            step();
            n++;
        end
        chk("rstmid_req_up", logic_wr_req, 1);
        chk("rstmid_level3", in_level, 3);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_async", {logic_wr_req, in_level, drain_busy}, '0);
        step();
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            step();
            if (logic_wr_req) n++;
        end
        chk("rstmid_no_writes", n, 0);
        chk("rstmid_level_after", in_level, 0);

        // Randomized traffic with a queue-based reference
        outst  = 0;
        active = 1'b0;
        dly    = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (logic_ack) begin
                if (!logic_wr_req) logic_ack = 1'b0;
            end else if (logic_wr_req) begin
                if (!active) begin
                    active = 1'b1;
                    dly    = int'($urandom_range(0, 5));
                    if (q.size() == 0) begin
                        chk("rnd_spurious_write", 1, 0);
                        cur = '0;
                    end else begin
                        cur = q.pop_front();
                    end
                    chk("rnd_entry", {logic_adr, logic_wr_data}, cur);
                end else begin
                    chk("rnd_hold", {logic_adr, logic_wr_data}, cur);
                end
                if (dly == 0) begin
                    logic_ack = 1'b1;
                    active    = 1'b0;
                    outst--;
                end else begin
                    dly--;
                end
            end
            if (cyc % 40 == 0) begin
                chk("rnd_level_bound", (int'(in_level) <= outst), 1);
                chk("rnd_no_err", err_req, 0);
            end
            if (cyc < 320 && outst < DEPTH && $urandom_range(0, 2) == 0) begin
                in_wr_req = 1'b1;
                in_adr    = ADR_W'($urandom);
                in_data   = DATA_W'($urandom);
                q.push_back({in_adr, in_data});
                outst++;
            end else begin
                in_wr_req = 1'b0;
            end
            mode_auto = (cyc >= 320) || ($urandom_range(0, 3) != 0);
            step();
        end
        chk("rnd_all_drained", {q.size(), outst}, '0);
        chk("rnd_final_state", {in_level, drain_busy, logic_wr_req, err_req}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
